mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port byte-wide memory between two requesters.
- Port 0 is the multicycle CPU (instruction fetch, LB and SB accesses). Port 1 is a secondary master, such as a program loader or debug/DMA engine.
- Each request is latched, presented to memory for a fixed number of wait cycles, then completed with a one-cycle ack.
- Arbitration is fixed priority to port 0, with a starvation guard that guarantees port 1 progress.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 1, extra memory wait cycles (0 = single-cycle memory).
- STARVE_MAX, 3, consecutive port-1 losses before port 1 is forced to win (legal range ≥1).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- adr0  input  AW  port 0 address.
- wd0  input  DW  port 0 write data.
- ack0  output  1  port 0 completion pulse.
- rd0  output  DW  port 0 read data.
- req1, we1, adr1, wd1, ack1, rd1: same as port 0, for port 1.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write strobe.
- mem_adr  output  AW  memory address.
- mem_wd  output  DW  memory write data.
- mem_rd  input  DW  memory read data.
- busy  output  1  high whenever state != IDLE.
- gnt  output  2  one-hot owner of the current transaction; 00 when idle.

Behaviour:
- Reset (synchronous, any state, including mid-transaction):
  - state=IDLE; gnt=00; ack0=ack1=0.
  - mem_en=mem_we=0; mem_adr=0; mem_wd=0.
  - rd0=rd1=0; starve counter=0; wait counter=0.
  - An in-flight transaction is abandoned with no ack.
- States: IDLE, BUSY, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - Samples req0/req1 at the clock edge.
  - Neither asserted: stay IDLE.
  - Otherwise select a winner; latch its we, adr and wd into mem_we/mem_adr/mem_wd.
  - Set gnt one-hot, set mem_en=1, load wait counter=MEM_LAT, go to BUSY.
- Arbitration:
  - Only req0: port 0 wins. Only req1: port 1 wins.
  - Both asserted: port 0 wins unless starve counter==STARVE_MAX, in which case port 1 wins.
  - Starve counter increments when port 0 wins while req1=1.
  - Starve counter clears to 0 whenever port 1 is granted.
  - Starve counter saturates at STARVE_MAX.
- BUSY:
  - mem_en=1; mem_adr, mem_we and mem_wd are held stable from the IDLE latch.
  - Wait counter nonzero: decrement it and stay.
  - Wait counter==0: go to DONE.
    - Read (mem_we=0): capture mem_rd into rd0 or rd1 of the granted port at that edge.
    - Write: rd registers are unchanged.
  - BUSY therefore lasts exactly MEM_LAT+1 cycles.
- DONE:
  - mem_en=0 and mem_we=0.
  - ackN of the granted port is high for exactly this one cycle; the other ack stays 0.
  - rdN is valid in DONE and holds until the next read on that port.
  - gnt clears to 00 on exit; next state is IDLE unconditionally. Requests are not sampled in DONE.
- Latency: request seen in IDLE cycle T gives ack in cycle T+MEM_LAT+2. Minimum turnaround between transactions is 3+MEM_LAT cycles.
- Requester rules:
  - Hold req, we, adr and wd stable until ack.
  - Drop req in the cycle after ack, unless a new transaction is intended.
  - A req held continuously is treated as back-to-back transactions.
  - Changes to non-granted port inputs during BUSY/DONE have no effect.
- Request withdrawn during BUSY: the transaction still completes and acks; no abort exists.
- ack0 and ack1 are never simultaneously high. mem_we is never high while mem_en=0.

Test Plan:
- Reset, then port 0 read: req0=1, we0=0, adr0=8'h10, mem model returns 8'hA5, MEM_LAT=1 -> mem_en high 2 cycles with mem_adr=8'h10; ack0 pulses once 3 cycles after the IDLE sample; rd0=8'hA5; ack1=0.
- Port 1 write: req1=1, we1=1, adr1=8'h20, wd1=8'h3C -> mem_we=1 and mem_wd=8'h3C for 2 cycles; ack1 pulses once; rd1 unchanged (0).
- Simultaneous requests held continuously, STARVE_MAX=3 -> grant sequence P0,P0,P0,P1, repeating; starve counter clears after each P1 grant.
- Back-to-back port 0 requests with MEM_LAT=0 -> ack0 every 3 cycles; busy low exactly one cycle (IDLE) between transactions.
- Reset asserted in the second BUSY cycle of a port 1 read -> next cycle state=IDLE, mem_en=0, gnt=00, no ack1, rd1=0, starve counter=0.
- Port 1 deasserts req1 mid-BUSY; port 0 changes adr0 during a port 1 transaction -> transaction completes with the original latched address, ack1 pulses, and port 0 is serviced only after DONE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus the single-port memory bus
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0, we0, ack0;
    logic          req1, we1, ack1;
    logic [AW-1:0] adr0, adr1, mem_adr;
    logic [DW-1:0] wd0, rd0, wd1, rd1;
    logic          mem_en, mem_we, busy;
    logic [DW-1:0] mem_wd, mem_rd;
    logic [1:0]    gnt;

    modport slave (
        input  req0, we0, adr0, wd0, req1, we1, adr1, wd1, mem_rd,
        output ack0, rd0, ack1, rd1, mem_en, mem_we, mem_adr, mem_wd, busy, gnt
    );

    modport master (
        output req0, we0, adr0, wd0, req1, we1, adr1, wd1, mem_rd,
        input  ack0, rd0, ack1, rd1, mem_en, mem_we, mem_adr, mem_wd, busy, gnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port fixed-priority arbiter for a single-port memory with a port-1 starvation guard
module mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int WW = $clog2(MEM_LAT + 2);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_adr_q, mem_adr_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic [DW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          pick1;

    assign bus.mem_en  = state_q == BUSY;
    assign bus.mem_we  = mem_we_q && state_q == BUSY;
    assign bus.mem_adr = mem_adr_q;
    assign bus.mem_wd  = mem_wd_q;
    assign bus.rd0     = rd0_q;
    assign bus.rd1     = rd1_q;
    assign bus.busy    = state_q != IDLE;
    assign bus.gnt     = gnt_q;
    assign bus.ack0    = state_q == DONE && gnt_q[0];
    assign bus.ack1    = state_q == DONE && gnt_q[1];

    // State register; reset abandons any in-flight transaction without an ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_wd_q  <= '0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            wait_q    <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            mem_we_q  <= mem_we_d;
            mem_adr_q <= mem_adr_d;
            mem_wd_q  <= mem_wd_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
            wait_q    <= wait_d;
            starve_q  <= starve_d;
        end
    end

    // Arbitration in IDLE, wait countdown in BUSY, one-cycle ack in DONE
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        mem_we_d  = mem_we_q;
        mem_adr_d = mem_adr_q;
        mem_wd_d  = mem_wd_q;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        wait_d    = wait_q;
        starve_d  = starve_q;
        pick1     = bus.req1 && (!bus.req0 || starve_q == SW'(STARVE_MAX));
        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d   = BUSY;
                    gnt_d     = pick1 ? 2'b10 : 2'b01;
                    mem_we_d  = pick1 ? bus.we1 : bus.we0;
                    mem_adr_d = pick1 ? bus.adr1 : bus.adr0;
                    mem_wd_d  = pick1 ? bus.wd1 : bus.wd0;
                    wait_d    = WW'(MEM_LAT);
                    starve_d  = pick1 ? '0 :
                                !bus.req1 ? starve_q :
                                starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + 1'b1;
                end
            end
            BUSY: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    state_d = DONE;
                    rd0_d   = !mem_we_q && gnt_q[0] ? bus.mem_rd : rd0_q;
                    rd1_d   = !mem_we_q && gnt_q[1] ? bus.mem_rd : rd1_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a transaction-level arbitration model
module tb_mem_arbiter;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int SMAX = 3;

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int            t;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic          req [2];
    logic          we  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wd  [2];
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] last_rd [2];
    txn_t q[$];
    int   ack_log[$];
    int   edge_n = 0, flush = 0, head = 0, starve = 0, free_at = 0;
    int   errors = 0, checks = 0;
    txn_t nt;
    logic p1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    assign bus.req0   = req[0];
    assign bus.we0    = we[0];
    assign bus.adr0   = adr[0];
    assign bus.wd0    = wd[0];
    assign bus.req1   = req[1];
    assign bus.we1    = we[1];
    assign bus.adr1   = adr[1];
    assign bus.wd1    = wd[1];
    assign bus.mem_rd = mem[bus.mem_adr];

    function automatic logic [DW-1:0] init_val(input int i);
        return i == 'h10 ? 8'hA5 : DW'(i * 29 + 7);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Memory device: combinational read, write applied while a write strobe is presented
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (bus.mem_en && bus.mem_we) mem[bus.mem_adr] = bus.mem_wd;
        end
    end

    // Reference model: arbiter is free again LAT+3 edges after each grant
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        last_rd = '{default: '0};
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset) begin
                flush   = q.size();
                starve  = 0;
                free_at = edge_n + 1;
                last_rd = '{default: '0};
            end else if (edge_n >= free_at && (req[0] || req[1])) begin
                p1      = req[1] && (!req[0] || starve == SMAX);
                nt.port = p1 ? 1 : 0;
                nt.we   = we[nt.port];
                nt.adr  = adr[nt.port];
                nt.wd   = wd[nt.port];
                nt.t    = edge_n;
                if (nt.we) begin
                    ref_mem[nt.adr] = nt.wd;
                    nt.rd = last_rd[nt.port];
                end else begin
                    nt.rd = ref_mem[nt.adr];
                end
                last_rd[nt.port] = nt.rd;
                starve  = p1 ? 0 : req[1] ? (starve < SMAX ? starve + 1 : SMAX) : starve;
                free_at = edge_n + LAT + 3;
                q.push_back(nt);
            end
        end
    end

    // Monitor: compares bus outputs every cycle against the oldest pending transaction
    initial begin
        int d;
        logic [1:0] g;
        forever begin
            @(negedge clk);
            if (head < flush) head = flush;
            if (head >= q.size()) begin
                check("idle_ctl", 32'({bus.busy, bus.mem_en, bus.mem_we, bus.gnt, bus.ack0, bus.ack1}), 32'd0);
            end else begin
                d = edge_n - q[head].t;
                g = q[head].port == 1 ? 2'b10 : 2'b01;
                if (d <= LAT) begin
                    check("busy_ctl", 32'({bus.busy, bus.mem_en, bus.mem_we, bus.gnt, bus.ack0, bus.ack1}),
                          32'({1'b1, 1'b1, q[head].we, g, 1'b0, 1'b0}));
                    check("mem_adr", 32'(bus.mem_adr), 32'(q[head].adr));
                    check("mem_wd", 32'(bus.mem_wd), 32'(q[head].wd));
                end else begin
                    check("done_ctl", 32'({bus.busy, bus.mem_en, bus.mem_we, bus.gnt, bus.ack0, bus.ack1}),
                          32'({1'b1, 1'b0, 1'b0, g, q[head].port == 0, q[head].port == 1}));
                    check("rd0", 32'(bus.rd0), 32'(q[head].port == 0 ? q[head].rd : last_rd[0]));
                    check("rd1", 32'(bus.rd1), 32'(q[head].port == 1 ? q[head].rd : last_rd[1]));
                    ack_log.push_back(q[head].port);
                    head++;
                end
            end
        end
    end

    task automatic wait_ack(input int p, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p == 1 ? bus.ack1 : bus.ack0) && n < budget);
        check($sformatf("ack%0d_seen", p), 32'(p == 1 ? bus.ack1 : bus.ack0), 32'd1);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.busy && n < budget);
        check("busy_seen", 32'(bus.busy), 32'd1);
    endtask

    task automatic set_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] v);
        req[p] = 1'b1;
        we[p]  = w;
        adr[p] = a;
        wd[p]  = v;
    endtask

    task automatic random_step();
        if ($urandom_range(299) == 0) begin
            reset = 1'b1;
            req   = '{default: 1'b0};
            return;
        end
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (req[p] && (p == 1 ? bus.ack1 : bus.ack0) && $urandom_range(1) == 0)
                req[p] = 1'b0;
            else if ((req[p] && (p == 1 ? bus.ack1 : bus.ack0)) || (!req[p] && $urandom_range(2) == 0))
                set_req(p, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
            else if (p == 1 && req[p] && $urandom_range(15) == 0)
                req[p] = 1'b0;
        end
    endtask

    initial begin
        int base, n;
        int ts[4];
        int pat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        req = '{default: 1'b0};
        we  = '{default: 1'b0};
        adr = '{default: '0};
        wd  = '{default: '0};
        repeat (3) @(negedge clk);
        check("reset_rd0", 32'(bus.rd0), 32'd0);
        check("reset_rd1", 32'(bus.rd1), 32'd0);
        reset = 1'b0;

        set_req(0, 1'b0, 8'h10, 8'h00);
        wait_ack(0, 20);
        check("p0_read_rd0", 32'(bus.rd0), 32'hA5);
        check("p0_read_ack1", 32'(bus.ack1), 32'd0);
        req[0] = 1'b0;

        set_req(1, 1'b1, 8'h20, 8'h3C);
        wait_ack(1, 20);
        check("p1_write_rd1", 32'(bus.rd1), 32'd0);
        check("p1_write_mem", 32'(mem[8'h20]), 32'h3C);
        req[1] = 1'b0;
        @(negedge clk);

        base = ack_log.size();
        set_req(0, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b0, 8'h02, 8'h00);
        n = 0;
        while (ack_log.size() < base + 8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        req = '{default: 1'b0};
        check("starve_count", 32'(ack_log.size() >= base + 8), 32'd1);
        for (int i = 0; i < 8 && base + i < ack_log.size(); i++)
            check($sformatf("starve_order%0d", i), 32'(ack_log[base + i]), 32'(pat[i]));
        repeat (LAT + 4) @(negedge clk);

        set_req(0, 1'b0, 8'h05, 8'h00);
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, 20);
            ts[i] = edge_n;
        end
        req[0] = 1'b0;
        for (int i = 1; i < 4; i++)
            check($sformatf("b2b_gap%0d", i), 32'(ts[i] - ts[i - 1]), 32'(LAT + 3));
        repeat (LAT + 4) @(negedge clk);

        set_req(1, 1'b0, 8'h55, 8'h00);
        wait_busy(10);
        req[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_ctl", 32'({bus.busy, bus.mem_en, bus.gnt, bus.ack1}), 32'd0);
        check("rst_mid_rd1", 32'(bus.rd1), 32'd0);
        repeat (2) @(negedge clk);

        set_req(1, 1'b0, 8'h30, 8'h00);
        wait_busy(10);
        req[1] = 1'b0;
        set_req(0, 1'b0, 8'h40, 8'h00);
        @(negedge clk);
        adr[0] = 8'h41;
        wait_ack(1, 10);
        wait_ack(0, 20);
        check("late_p0_rd0", 32'(bus.rd0), 32'(init_val('h41)));
        req[0] = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            random_step();
        end
        reset = 1'b0;
        req   = '{default: 1'b0};
        repeat (LAT + 6) @(negedge clk);
        check("drained", 32'(head >= q.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
